mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage data-memory access controller for the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It turns the EX/MEM address, store data and control into a handshaked data-memory bus transaction, aligns and extends load data, and stalls the pipeline until the access completes. Its `data_mem_output` is the value MEM/WB captures as load data.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles waiting for `dmem_ready` before the access is aborted; range 1..255.

Ports:
- `clk`  in  1  single pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_read`  in  1  EX/MEM control: current instruction is a load.
- `mem_write`  in  1  EX/MEM control: current instruction is a store. Never asserted together with `mem_read`.
- `mem_size`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `mem_signed`  in  1  load sign-extend (1) or zero-extend (0).
- `MEM_out_1`  in  32  ALU result, used as the byte address.
- `MEM_out_2`  in  32  store data (register Rm/Rt).
- `dmem_req`  out  1  bus request; held until accepted.
- `dmem_we`  out  1  bus write strobe.
- `dmem_addr`  out  32  word-aligned address, `{MEM_out_1[31:2], 2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_ready`  in  1  bus completion; read data is valid in the same cycle.
- `dmem_rdata`  in  32  bus read data.
- `mem_stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; hold MEM/WB input.
- `data_mem_output`  out  32  aligned and extended load result to MEM/WB.
- `misalign_err`  out  1  one-cycle pulse in DONE for a misaligned access.
- `bus_err`  out  1  one-cycle pulse in DONE for a timeout.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE:** an access is pending when `mem_read | mem_write`.
  - Aligned access → REQ.
  - Misaligned access (half with `addr[0]`=1, or word with `addr[1:0]`≠0) → DONE with `misalign_err`. No bus request is issued.
- **REQ:**
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_be` and `dmem_wdata` are registered on entry and held stable.
  - Timeout counter is 8 bits, cleared on entry, incremented each REQ cycle.
  - `dmem_ready` → capture the aligned load result, drop `dmem_req`, go to DONE.
  - Counter reaching `TIMEOUT_CYCLES-1` without `dmem_ready` → drop `dmem_req`, set `data_mem_output`=0, go to DONE with `bus_err`.
- **DONE:** lasts exactly one cycle, then always → IDLE. The pipeline advances on the DONE edge. The next access therefore starts in IDLE, and back-to-back accesses are not merged.
- `mem_stall` is combinational: `(mem_read | mem_write) && state != DONE`. It is 0 for non-memory instructions.
- Byte enables (little-endian):
  - Byte: one-hot on `addr[1:0]`.
  - Half: `4'b0011` or `4'b1100` by `addr[1]`.
  - Word: `4'b1111`.
- Store data: byte → `{4{MEM_out_2[7:0]}}`, half → `{2{MEM_out_2[15:0]}}`, word → unchanged.
- Load data: select the lane by `addr[1:0]`, then sign- or zero-extend to 32 bits. Stores leave `data_mem_output` at 0 in DONE.
- `data_mem_output` holds its value outside DONE.
- `mem_size` of 11 behaves exactly as 10.

## Timing
- Reset values: state IDLE; all outputs 0; counter 0.
- Reset asserted mid-REQ drops `dmem_req` immediately (asynchronous) and abandons the transaction. Any `dmem_ready` arriving after reset is ignored.
- Aligned access, ready on the first REQ cycle:
  - cycle 0: IDLE, access seen, `mem_stall`=1.
  - cycle 1: REQ, `dmem_req`=1, `dmem_ready`=1.
  - cycle 2: DONE, `mem_stall`=0, `data_mem_output` valid.
  - This is the minimum: 2 stall cycles.
- Each extra cycle of `dmem_ready` latency adds one stall cycle.
- Misaligned access: cycle 0 IDLE, cycle 1 DONE; 1 stall cycle.
- Timeout: DONE is entered after exactly `TIMEOUT_CYCLES` REQ cycles.
- `dmem_ready` outside REQ is ignored.
- Bus outputs must not change while `dmem_req`=1.

## Structure
- Package `mem_pkg`:
  - `mem_size_t` enum: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - `mau_state_t` enum: IDLE, REQ, DONE.
  - Width constants for the counter and bus.
- Sub-module `mem_load_align`: purely combinational lane select and extension. Inputs: `rdata`, `addr[1:0]`, `size`, `signed`. Output: 32-bit result.
- The top level holds the FSM, counter, store-lane replication and byte-enable generation.

## Test plan
- Word load, addr 0x100, `dmem_ready` on the first REQ cycle, rdata 0xDEADBEEF → `dmem_addr` 0x100, `dmem_be` 1111, `data_mem_output` 0xDEADBEEF in DONE at cycle 2, `mem_stall` high for cycles 0–1 only.
- Signed byte load, addr 0x103, rdata 0x80FF1234 → `dmem_be` 1000, output 0xFFFFFF80. Unsigned byte load, same addr → 0x00000080. Signed half load, addr 0x102 → 0xFFFF80FF.
- Byte store, addr 0x201, `MEM_out_2` 0x000000AB, ready after 3 REQ cycles → `dmem_we`=1, `dmem_be` 0010, `dmem_wdata` 0xABABABAB, bus outputs stable for 3 REQ cycles, 4 stall cycles total.
- Word load at addr 0x102 → no `dmem_req`, `misalign_err` pulse in cycle 1, `data_mem_output` 0.
- `TIMEOUT_CYCLES`=4, `dmem_ready` never asserted → `dmem_req` high for exactly 4 cycles, then `bus_err` pulse, `data_mem_output` 0, back to IDLE.
- `rst_n` asserted in the 2nd REQ cycle, then `dmem_ready` pulsed after release → all outputs 0 immediately, state IDLE, stale ready ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and widths for the MEM-stage data-memory access controller.
package mem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } mau_state_t;

    // Reserved size 2'b11 falls into the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (mem_size_t'(size))
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            default: bad = (lo != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load lane select followed by sign or zero extension.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr,
    input  logic [1:0]        size,
    input  logic              is_signed,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'h00;
        case (addr)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = 8'h00;
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

        result = rdata;
        case (mem_size_t'(size))
            SZ_BYTE: result = {{24{is_signed & byte_lane[7]}}, byte_lane};
            SZ_HALF: result = {{16{is_signed & half_lane[15]}}, half_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: turns EX/MEM control into one handshaked bus access,
// stalls the pipeline until it completes, and aligns load data for MEM/WB.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic [31:0] MEM_out_1,
    input  logic [31:0] MEM_out_2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] data_mem_output,
    output logic        misalign_err,
    output logic        bus_err,
    output logic [1:0]  fsm_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mau_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              pending, misaligned;
    logic              start_req, flag_misalign, finish_ok, finish_timeout;
    logic [BE_W-1:0]   be_next;
    logic [DATA_W-1:0] wdata_next, load_result;
    logic [1:0]        addr_lo_q, size_q;
    logic              signed_q;

    assign pending    = mem_read | mem_write;
    assign misaligned = is_misaligned(mem_size, MEM_out_1[1:0]);
    assign fsm_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pending) state_next = misaligned ? DONE : REQ;
            REQ:     if (dmem_ready || cnt == CNT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_stall      = pending && (state != DONE);
        start_req      = (state == IDLE) && pending && !misaligned;
        flag_misalign  = (state == IDLE) && pending && misaligned;
        finish_ok      = (state == REQ) && dmem_ready;
        finish_timeout = (state == REQ) && !dmem_ready && (cnt == CNT_LAST);
    end

    // Little-endian lane enables; stores replicate data across every lane.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = MEM_out_2;
        case (mem_size_t'(mem_size))
            SZ_BYTE: begin
                be_next    = 4'b0001 << MEM_out_1[1:0];
                wdata_next = {4{MEM_out_2[7:0]}};
            end
            SZ_HALF: begin
                be_next    = MEM_out_1[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{MEM_out_2[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = MEM_out_2;
            end
        endcase
    end

    mem_load_align u_load_align (
        .rdata     (dmem_rdata),
        .addr      (addr_lo_q),
        .size      (size_q),
        .is_signed (signed_q),
        .result    (load_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_be         <= '0;
            dmem_wdata      <= '0;
            addr_lo_q       <= '0;
            size_q          <= '0;
            signed_q        <= 1'b0;
            cnt             <= '0;
            data_mem_output <= '0;
            misalign_err    <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            if (start_req) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_write;
                dmem_addr  <= {MEM_out_1[31:2], 2'b00};
                dmem_be    <= be_next;
                dmem_wdata <= wdata_next;
                addr_lo_q  <= MEM_out_1[1:0];
                size_q     <= mem_size;
                signed_q   <= mem_signed;
                cnt        <= '0;
            end else if (state == REQ) begin
                cnt <= cnt + 1'b1;
            end
            if (finish_ok || finish_timeout) dmem_req <= 1'b0;

            if (finish_ok)
                data_mem_output <= dmem_we ? '0 : load_result;
            else if (finish_timeout || flag_misalign)
                data_mem_output <= '0;

            misalign_err <= flag_misalign;
            bus_err      <= finish_timeout;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a short bus timeout.
module tb_mem_access_unit;

    localparam int TMO = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic        clk, rst_n;
    logic        mem_read, mem_write, mem_signed;
    logic [1:0]  mem_size;
    logic [31:0] MEM_out_1, MEM_out_2;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        mem_stall, misalign_err, bus_err;
    logic [31:0] data_mem_output;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct packed {
        logic [7:0]  stall_cycles;
        logic [7:0]  req_cycles;
        logic [7:0]  req_high;
        logic [7:0]  done_cycle;
        logic        stable;
        logic        done_seen;
        logic        stall_in_done;
        logic        we_o;
        logic        misalign;
        logic        buserr;
        logic [3:0]  be_o;
        logic [31:0] addr_o;
        logic [31:0] wdata_o;
        logic [31:0] data_out;
    } obs_t;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_signed(mem_signed), .MEM_out_1(MEM_out_1), .MEM_out_2(MEM_out_2),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .data_mem_output(data_mem_output), .misalign_err(misalign_err),
        .bus_err(bus_err), .fsm_state(fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * a[1:0])) & 32'h0000_00FF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * a[1])) & 32'h0000_FFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return 4'(1 << a[1:0]);
        if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // Driver: starts in IDLE just after a rising edge; lat = REQ cycle that sees
    // dmem_ready (0 = never). Returns one cycle after DONE, back in IDLE.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdat, input int lat, output obs_t o);
        o = '0;
        o.stable = 1'b1;
        mem_read = rd; mem_write = wr; mem_size = sz; mem_signed = sg;
        MEM_out_1 = addr; MEM_out_2 = wd;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (mem_stall) o.stall_cycles++;
            if (dmem_req) o.req_high++;
            if (fsm_state == ST_DONE) begin
                o.done_seen = 1'b1;
                o.done_cycle = 8'(cyc);
                o.stall_in_done = mem_stall;
                o.misalign = misalign_err;
                o.buserr = bus_err;
                o.data_out = data_mem_output;
                break;
            end
            if (fsm_state == ST_REQ) begin
                o.req_cycles++;
                if (o.req_cycles == 8'd1) begin
                    o.we_o = dmem_we; o.be_o = dmem_be;
                    o.addr_o = dmem_addr; o.wdata_o = dmem_wdata;
                end else if (dmem_we !== o.we_o || dmem_be !== o.be_o ||
                             dmem_addr !== o.addr_o || dmem_wdata !== o.wdata_o) begin
                    o.stable = 1'b0;
                end
                if (dmem_req !== 1'b1) o.stable = 1'b0;
                if (lat != 0 && int'(o.req_cycles) == lat) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = rdat;
                end
            end
        end
        mem_read = 1'b0; mem_write = 1'b0; dmem_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_bus: got req=%b we=%b addr=%h be=%b wdata=%h, expected all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        checks++;
        if ({data_mem_output, misalign_err, bus_err, mem_stall, fsm_state} !== '0) begin
            errors++;
            $display("FAIL reset_misc: got data=%h mis=%b bus=%b stall=%b state=%0d, expected all 0",
                     data_mem_output, misalign_err, bus_err, mem_stall, fsm_state);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_load();
        obs_t o;
        logic [31:0] e;
        exp_q.push_back(32'hDEAD_BEEF);
        run_access(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, o);
        e = exp_q.pop_front();
        checks++;
        if (o.data_out !== e || !o.done_seen) begin
            errors++;
            $display("FAIL word_load data: got %h (done=%b), expected %h", o.data_out, o.done_seen, e);
        end
        checks++;
        if (o.addr_o !== 32'h100 || o.be_o !== 4'b1111 || o.we_o !== 1'b0) begin
            errors++;
            $display("FAIL word_load bus: got addr=%h be=%b we=%b, expected 100 1111 0", o.addr_o, o.be_o, o.we_o);
        end
        checks++;
        if (o.done_cycle !== 8'd2 || o.stall_cycles !== 8'd2 || o.stall_in_done !== 1'b0) begin
            errors++;
            $display("FAIL word_load timing: got done_cycle=%0d stalls=%0d stall_in_done=%b, expected 2 2 0",
                     o.done_cycle, o.stall_cycles, o.stall_in_done);
        end
    endtask

    task automatic test_sub_word_loads();
        obs_t o;
        logic [31:0] e;
        logic [31:0] addrs[3] = '{32'h103, 32'h103, 32'h102};
        logic [1:0]  szs[3]   = '{2'd0, 2'd0, 2'd1};
        logic        sgs[3]   = '{1'b1, 1'b0, 1'b1};
        logic [31:0] exps[3]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
        logic [3:0]  bes[3]   = '{4'b1000, 4'b1000, 4'b1100};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exps[i]);
            run_access(1, 0, szs[i], sgs[i], addrs[i], 32'h0, 32'h80FF_1234, 1, o);
            e = exp_q.pop_front();
            checks++;
            if (o.data_out !== e || o.be_o !== bes[i]) begin
                errors++;
                $display("FAIL sub_word_load[%0d]: got data=%h be=%b, expected data=%h be=%b",
                         i, o.data_out, o.be_o, e, bes[i]);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(1, 0, 2'd2, 0, 32'h400, 32'h0, 32'h1111_1111, 0, o);
        checks++;
        if (o.req_high !== 8'(TMO) || o.req_cycles !== 8'(TMO) || o.done_cycle !== 8'(TMO + 1)) begin
            errors++;
            $display("FAIL timeout timing: got req_high=%0d req_cycles=%0d done_cycle=%0d, expected %0d %0d %0d",
                     o.req_high, o.req_cycles, o.done_cycle, TMO, TMO, TMO + 1);
        end
        checks++;
        if (o.buserr !== 1'b1 || o.data_out !== 32'h0 || o.misalign !== 1'b0) begin
            errors++;
            $display("FAIL timeout flags: got bus_err=%b data=%h mis=%b, expected 1 0 0",
                     o.buserr, o.data_out, o.misalign);
        end
        @(negedge clk);
        checks++;
        if (fsm_state !== ST_IDLE || bus_err !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout after: got state=%0d bus_err=%b req=%b, expected 0 0 0", fsm_state, bus_err, dmem_req);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_loads();
        obs_t o;
        logic [31:0] a, rd, e;
        logic [1:0] sz;
        logic sg;
        int lat;
        for (int i = 0; i < 8; i++) begin
            sz = 2'($urandom_range(0, 3));
            a = $urandom();
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz[1]) a[1:0] = 2'b00;
            rd = $urandom();
            sg = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 3);
            exp_q.push_back(model_load(rd, a, sz, sg));
            run_access(1, 0, sz, sg, a, 32'h0, rd, lat, o);
            e = exp_q.pop_front();
            checks++;
            if (o.data_out !== e || o.be_o !== model_be(a, sz) || o.addr_o !== {a[31:2], 2'b00} ||
                int'(o.stall_cycles) != lat + 1 || !o.stable) begin
                errors++;
                $display("FAIL random_load[%0d]: got data=%h be=%b addr=%h stalls=%0d stable=%b, expected %h %b %h %0d 1",
                         i, o.data_out, o.be_o, o.addr_o, o.stall_cycles, o.stable,
                         e, model_be(a, sz), {a[31:2], 2'b00}, lat + 1);
            end
        end
    endtask

    task automatic test_stores();
        obs_t o;
        logic [31:0] addrs[3] = '{32'h201, 32'h202, 32'h204};
        logic [1:0]  szs[3]   = '{2'd0, 2'd1, 2'd3};
        logic [31:0] wds[3]   = '{32'h0000_00AB, 32'h1234_CDEF, 32'h1234_5678};
        logic [31:0] exw[3]   = '{32'hABAB_ABAB, 32'hCDEF_CDEF, 32'h1234_5678};
        logic [3:0]  bes[3]   = '{4'b0010, 4'b1100, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h0);
            run_access(0, 1, szs[i], 0, addrs[i], wds[i], 32'hFFFF_FFFF, 3, o);
            checks++;
            if (o.we_o !== 1'b1 || o.be_o !== bes[i] || o.wdata_o !== exw[i] ||
                o.addr_o !== {addrs[i][31:2], 2'b00}) begin
                errors++;
                $display("FAIL store[%0d] bus: got we=%b be=%b wdata=%h addr=%h, expected 1 %b %h %h",
                         i, o.we_o, o.be_o, o.wdata_o, o.addr_o, bes[i], exw[i], {addrs[i][31:2], 2'b00});
            end
            checks++;
            if (!o.stable || o.req_cycles !== 8'd3 || o.stall_cycles !== 8'd4 ||
                o.data_out !== exp_q.pop_front()) begin
                errors++;
                $display("FAIL store[%0d] timing: got stable=%b req_cycles=%0d stalls=%0d data=%h, expected 1 3 4 0",
                         i, o.stable, o.req_cycles, o.stall_cycles, o.data_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        exp_q.push_back(32'h0000_5A5A);
        exp_q.push_back(32'hFFFF_A5A5);
        run_access(1, 0, 2'd1, 0, 32'h500, 32'h0, 32'h0000_5A5A, 1, o1);
        checks++;
        if (data_mem_output !== 32'h0000_5A5A) begin
            errors++;
            $display("FAIL hold_after_done: got %h, expected 00005a5a", data_mem_output);
        end
        run_access(1, 0, 2'd1, 1, 32'h502, 32'h0, 32'hA5A5_0000, 2, o2);
        checks++;
        if (o1.data_out !== exp_q.pop_front() || o1.done_cycle !== 8'd2) begin
            errors++;
            $display("FAIL back_to_back first: got data=%h done_cycle=%0d, expected 00005a5a 2", o1.data_out, o1.done_cycle);
        end
        checks++;
        if (o2.data_out !== exp_q.pop_front() || o2.done_cycle !== 8'd3) begin
            errors++;
            $display("FAIL back_to_back second: got data=%h done_cycle=%0d, expected ffffa5a5 3", o2.data_out, o2.done_cycle);
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        logic [31:0] addrs[2] = '{32'h102, 32'h301};
        logic [1:0]  szs[2]   = '{2'd2, 2'd1};
        for (int i = 0; i < 2; i++) begin
            run_access(i == 0, i == 1, szs[i], 0, addrs[i], 32'h7777_7777, 32'h3333_3333, 1, o);
            checks++;
            if (o.req_high !== 8'd0 || o.misalign !== 1'b1 || o.data_out !== 32'h0 ||
                o.done_cycle !== 8'd1 || o.stall_cycles !== 8'd1 || o.buserr !== 1'b0) begin
                errors++;
                $display("FAIL misalign[%0d]: got req_high=%0d mis=%b data=%h done_cycle=%0d stalls=%0d bus=%b, expected 0 1 0 1 1 0",
                         i, o.req_high, o.misalign, o.data_out, o.done_cycle, o.stall_cycles, o.buserr);
            end
        end
    endtask

    task automatic test_reset_mid_req();
        mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2; mem_signed = 1'b0;
        MEM_out_1 = 32'h300;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (fsm_state !== ST_REQ || dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_req setup: got state=%0d req=%b, expected 1 1", fsm_state, dmem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || fsm_state !== ST_IDLE || dmem_addr !== 32'h0 || dmem_be !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid_req async: got req=%b state=%0d addr=%h be=%b, expected 0 0 0 0",
                     dmem_req, fsm_state, dmem_addr, dmem_be);
        end
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (fsm_state !== ST_IDLE || dmem_req !== 1'b0 || data_mem_output !== 32'h0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL stale_ready: got state=%0d req=%b data=%h stall=%b, expected 0 0 0 0",
                     fsm_state, dmem_req, data_mem_output, mem_stall);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'd0; mem_signed = 1'b0;
        MEM_out_1 = '0; MEM_out_2 = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_word_load();
        test_sub_word_loads();
        test_timeout();
        test_random_loads();
        test_stores();
        test_back_to_back();
        test_misalign();
        test_reset_mid_req();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
